// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexed NUM_DIGITS-digit 7-segment driver. Digits and decimal
// points are latched into shadow registers on 'load'. A divider steps the scan
// index every SCAN_DIV cycles, and the outputs are registered one cycle behind
// the scan state. Leading-zero blanking is optional and controlled by 'lz_blank'.
//
// Build option: define SEG7_HEX_EN to show hex glyphs for codes 10-15.
// Without it, codes 10-15 are shown blank. The decimal point is driven in
// both builds.
//
// No valid/ready handshake is used. 'load' is a plain capture strobe that is
// sampled on every rising edge. There is no back-pressure. A load never
// disturbs the scan position.
module seg7_scan_driver #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 50000
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    lz_blank,
  output logic [NUM_DIGITS-1:0]   scan_select,
  output logic [7:0]              seg7,
  output logic                    frame_done
);

  // Counter widths. The divider needs at least one bit even when SCAN_DIV=1.
  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

  // Shadow registers
  logic [4*NUM_DIGITS-1:0] r_digit_q;
  logic [NUM_DIGITS-1:0]   r_dp_q;

  // Scan state
  logic [IDX_W-1:0] r_idx;
  logic [DIV_W-1:0] r_div;
  logic             r_wrap_pend;

  // Output registers
  logic [NUM_DIGITS-1:0] r_scan_select;
  logic [7:0]            r_seg7;
  logic                  r_frame_done;

  // Combinational helpers
  logic                  w_div_tc;
  logic                  w_wrap;
  logic [3:0]            w_cur_code;
  logic                  w_cur_dp;
  logic [NUM_DIGITS-1:0] w_sel_n;
  logic [NUM_DIGITS-1:0] w_lead_zero;
  logic                  w_cur_blank;
  logic [6:0]            w_cur_glyph;

  // Glyph lookup {a,b,c,d,e,f,g}. Codes 10-15 depend on the hex build option.
  function automatic logic [6:0] glyph(input logic [3:0] code);
    logic [6:0] g;
    g = 7'b0000000;
    case (code)
      4'd0:  g = 7'b1111110;
      4'd1:  g = 7'b0110000;
      4'd2:  g = 7'b1101101;
      4'd3:  g = 7'b1111001;
      4'd4:  g = 7'b0110011;
      4'd5:  g = 7'b1011011;
      4'd6:  g = 7'b1011111;
      4'd7:  g = 7'b1110000;
      4'd8:  g = 7'b1111111;
      4'd9:  g = 7'b1111011;
`ifdef SEG7_HEX_EN
      4'd10: g = 7'b1110111;
      4'd11: g = 7'b0011111;
      4'd12: g = 7'b1001110;
      4'd13: g = 7'b0111101;
      4'd14: g = 7'b1001111;
      4'd15: g = 7'b1000111;
`else
      default: g = 7'b0000000;
`endif
    endcase
    return g;
  endfunction

  // Divider terminal count, and the last-digit terminal count that closes a frame
  always_comb begin
    w_div_tc = (r_div == DIV_LAST);
    w_wrap   = w_div_tc && (r_idx == IDX_LAST);
  end

  // Shadow capture. Reset takes priority over a simultaneous load.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_digit_q <= '0;
      r_dp_q    <= '0;
    end else if (load) begin
      r_digit_q <= digits_in;
      r_dp_q    <= dp_in;
    end
  end

  // Scan divider and digit index. r_wrap_pend marks the first cycle of a new frame.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_idx       <= '0;
      r_div       <= '0;
      r_wrap_pend <= 1'b0;
    end else begin
      r_wrap_pend <= w_wrap;
      if (w_div_tc) begin
        r_div <= '0;
        if (w_wrap) begin
          r_idx <= '0;
        end else begin
          r_idx <= r_idx + 1'b1;
        end
      end else begin
        r_div <= r_div + 1'b1;
      end
    end
  end

  // Select the current digit's code, DP and active-low select vector
  always_comb begin
    w_cur_code = 4'd0;
    w_cur_dp   = 1'b0;
    w_sel_n    = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_code = r_digit_q[4*i +: 4];
        w_cur_dp   = r_dp_q[i];
        w_sel_n[i] = 1'b0;
      end
    end
  end

  // w_lead_zero[i] is set when digit i and every higher digit are zero
  always_comb begin
    logic v_run;
    v_run       = 1'b1;
    w_lead_zero = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      v_run          = v_run && (r_digit_q[4*i +: 4] == 4'd0);
      w_lead_zero[i] = v_run;
    end
  end

  // Blanking decision for the current digit. Digit 0 is never blanked.
  always_comb begin
    w_cur_blank = 1'b0;
    w_cur_glyph = glyph(w_cur_code);
    for (int i = 1; i < NUM_DIGITS; i++) begin
      if (r_idx == IDX_W'(i)) begin
        w_cur_blank = lz_blank && w_lead_zero[i];
      end
    end
  end

  // Registered outputs, one cycle behind the scan state
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_scan_select <= '1;
      r_seg7        <= 8'h00;
      r_frame_done  <= 1'b0;
    end else begin
      r_scan_select <= w_sel_n;
      r_seg7        <= {w_cur_dp, (w_cur_blank ? 7'b0000000 : w_cur_glyph)};
      r_frame_done  <= r_wrap_pend;
    end
  end

  assign scan_select = r_scan_select;
  assign seg7        = r_seg7;
  assign frame_done  = r_frame_done;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver with NUM_DIGITS=4 and SCAN_DIV=3. The expected
// outputs come from the count of cycles since reset release and a copy of the
// latched digits.
module tb_seg7_scan_driver;

  localparam int N     = 4;
  localparam int DIV   = 3;
  localparam int FRAME = N * DIV;

  // Clock and reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            resetn;
  logic            load;
  logic [4*N-1:0]  digits_in;
  logic [N-1:0]    dp_in;
  logic            lz_blank;
  logic [N-1:0]    scan_select;
  logic [7:0]      seg7;
  logic            frame_done;

  seg7_scan_driver #(
    .NUM_DIGITS(N),
    .SCAN_DIV  (DIV)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .load       (load),
    .digits_in  (digits_in),
    .dp_in      (dp_in),
    .lz_blank   (lz_blank),
    .scan_select(scan_select),
    .seg7       (seg7),
    .frame_done (frame_done)
  );

  // Scoreboard counters
  int n_pass  = 0;
  int n_fail  = 0;
  int n_total = 0;

  // Reference model state
  logic [6:0] glyph_tbl [16];
  logic [3:0] m_dig [N];
  logic [N-1:0] m_dp;
  int m_k;   // rising edges since reset was released

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s k=%0d observed=%h expected=%h", tag, m_k, obs, exp);
    end
  endtask

  // One clock. The expectation is computed from the pre-edge model and the
  // current inputs. The model is updated, one edge is taken, and the outputs
  // are sampled on the falling edge.
  task automatic step();
    logic [N-1:0] e_sel;
    logic [7:0]   e_seg;
    logic         e_fd;
    int d;
    int hi;
    if (!resetn) begin
      e_sel = '1;
      e_seg = 8'h00;
      e_fd  = 1'b0;
      m_k   = 0;
      for (int i = 0; i < N; i++) m_dig[i] = 4'd0;
      m_dp = '0;
    end else begin
      m_k++;
      d = ((m_k - 1) / DIV) % N;
      e_sel    = '1;
      e_sel[d] = 1'b0;
      hi = -1;
      for (int i = 0; i < N; i++) if (m_dig[i] != 4'd0) hi = i;
      e_seg = {m_dp[d], ((lz_blank && d > 0 && d > hi) ? 7'd0 : glyph_tbl[m_dig[d]])};
      e_fd  = (m_k > 1) && (((m_k - 1) % FRAME) == 0);
      if (load) begin
        for (int i = 0; i < N; i++) m_dig[i] = digits_in[4*i +: 4];
        m_dp = dp_in;
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("scan_select", 8'(scan_select), 8'(e_sel));
    check("seg7", seg7, e_seg);
    check("frame_done", 8'(frame_done), 8'(e_fd));
  endtask

  task automatic do_load(input logic [4*N-1:0] d, input logic [N-1:0] p);
    load      = 1'b1;
    digits_in = d;
    dp_in     = p;
    step();
    load = 1'b0;
  endtask

  initial begin
    glyph_tbl[0] = 7'b1111110; glyph_tbl[1] = 7'b0110000;
    glyph_tbl[2] = 7'b1101101; glyph_tbl[3] = 7'b1111001;
    glyph_tbl[4] = 7'b0110011; glyph_tbl[5] = 7'b1011011;
    glyph_tbl[6] = 7'b1011111; glyph_tbl[7] = 7'b1110000;
    glyph_tbl[8] = 7'b1111111; glyph_tbl[9] = 7'b1111011;
`ifdef SEG7_HEX_EN
    glyph_tbl[10] = 7'b1110111; glyph_tbl[11] = 7'b0011111;
    glyph_tbl[12] = 7'b1001110; glyph_tbl[13] = 7'b0111101;
    glyph_tbl[14] = 7'b1001111; glyph_tbl[15] = 7'b1000111;
`else
    for (int i = 10; i < 16; i++) glyph_tbl[i] = 7'b0000000;
`endif
    for (int i = 0; i < N; i++) m_dig[i] = 4'd0;
    m_dp = '0;
    m_k  = 0;

    resetn    = 1'b0;
    load      = 1'b0;
    digits_in = '0;
    dp_in     = '0;
    lz_blank  = 1'b0;

    // Reset held for two cycles, then the first digit-0 output
    repeat (2) step();
    resetn = 1'b1;
    step();

    // Scan order and rate with 4321, across more than two frames
    do_load(16'h4321, 4'b0000);
    repeat (30) step();

    // Leading-zero blanking on, then off
    lz_blank = 1'b1;
    do_load(16'h0070, 4'b0000);
    repeat (12) step();
    lz_blank = 1'b0;
    repeat (12) step();

    // Decimal point on digit 2 over all-zero digits, with and without blanking
    do_load(16'h0000, 4'b0100);
    repeat (12) step();
    lz_blank = 1'b1;
    repeat (12) step();
    lz_blank = 1'b0;

    // Hex / invalid codes
    do_load(16'hFA00, 4'b0000);
    repeat (12) step();

    // Load on a terminal-count edge
    for (int t = 0; t < DIV && (m_k % DIV) != DIV - 1; t++) step();
    do_load(16'h9856, 4'b1010);
    repeat (6) step();

    // Load together with reset must leave the shadow registers at zero
    resetn = 1'b0;
    do_load(16'h8888, 4'b1111);
    resetn = 1'b1;
    repeat (12) step();

    // Reset pulsed mid-frame: scan restarts at digit 0 without a frame pulse
    do_load(16'h1234, 4'b0001);
    repeat (5) step();
    resetn = 1'b0;
    step();
    resetn = 1'b1;
    repeat (15) step();

    // Randomized traffic with occasional resets
    repeat (300) begin
      load      = ($urandom_range(0, 3) == 0);
      digits_in = 16'($urandom_range(0, 65535) >> (4 * $urandom_range(0, 4)));
      dp_in     = 4'($urandom_range(0, 15));
      lz_blank  = 1'($urandom_range(0, 1));
      resetn    = ($urandom_range(0, 59) != 0);
      step();
    end
    load   = 1'b0;
    resetn = 1'b1;
    repeat (12) step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Multi-digit, time-multiplexed 7-segment display driver for the lab-board FPGA_NUM displays. It generalises the single-digit BCD decoder to NUM_DIGITS digits. It latches a packed digit word on a load strobe, cycles the scan select through the digits at a programmable rate, and drives registered segment patterns. It also provides per-digit decimal points, optional leading-zero blanking and a frame-done pulse. It sits between counter/datapath blocks and the board's shared seg7/scan pins.

## Interface
- NUM_DIGITS, 4: number of scanned digits; legal range 2..8.
- SCAN_DIV, 50000: clock cycles each digit stays selected; legal minimum 1.

- clk  in  1  system clock; all logic on rising edge.
- resetn  in  1  synchronous, active-low reset.
- load  in  1  when high at an edge, capture digits_in and dp_in.
- digits_in  in  4*NUM_DIGITS  packed 4-bit codes; digit i is bits [4i+3:4i]; digit 0 is least significant.
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit.
- lz_blank  in  1  level; 1 = suppress leading zeros.
- scan_select  out  NUM_DIGITS  one-hot active-low; bit i = 0 selects digit i.
- seg7  out  8  {DP,a,b,c,d,e,f,g}, active-high.
- frame_done  out  1  one-cycle pulse at the start of each new scan frame.

## Operation
- Shadow registers: digit_q[4*NUM_DIGITS] and dp_q[NUM_DIGITS], written only when load=1. Scan state is not disturbed by a load.
- Divider div counts 0..SCAN_DIV-1. At terminal count it returns to 0 and index advances.
- Index advances idx → idx+1, and wraps NUM_DIGITS-1 → 0.
- Glyphs {a..g} for codes 0-9:
  - 0 1111110
  - 1 0110000
  - 2 1101101
  - 3 1111001
  - 4 0110011
  - 5 1011011
  - 6 1011111
  - 7 1110000
  - 8 1111111
  - 9 1111011
- Codes 10-15 are handled per Configuration.
- Leading-zero blanking, when lz_blank=1:
  - Digit i > 0 is blanked (a..g = 0) if digit i and every higher digit are 0.
  - Digit 0 is never blanked.
  - DP follows dp_q regardless of blanking.
- Output registers:
  - scan_select is driven as ~(1<<idx).
  - seg7 is driven as {dp_q[idx], glyph(digit_q[idx])}, with blanking applied.
- frame_done is registered. It is high for exactly the first output cycle in which scan_select shows digit 0 after a wrap. It is not asserted after reset.
- Reset values:
  - scan_select = all ones
  - seg7 = 8'h00
  - frame_done = 0
  - digit_q = 0, dp_q = 0
  - idx = 0, div = 0
- Reset mid-operation: the next edge with resetn=0 forces all reset values. It overrides a simultaneous load.

## Timing
- Output latency is one cycle from internal state.
- Load at edge N: the new value is visible on seg7 after edge N+1, if the digit is selected.
- After resetn deasserts at edge R, the first outputs appear after edge R+1, showing digit 0.
- Each digit is shown for exactly SCAN_DIV cycles. A full frame is NUM_DIGITS*SCAN_DIV cycles.
- SCAN_DIV=1: the index advances every cycle.
- load coincident with terminal count: both take effect at the same edge. The next digit shows the new data.
- lz_blank is combinational into the output register, so a change takes effect one cycle later.

## Configuration
- SEG7_HEX_EN defined: codes 10-15 display hex glyphs {a..g}:
  - A 1110111
  - b 0011111
  - C 1001110
  - d 0111101
  - E 1001111
  - F 1000111
- SEG7_HEX_EN undefined: codes 10-15 display blank, a..g = 0. DP is still driven from dp_q.

## Test plan
- Reset: NUM_DIGITS=4, SCAN_DIV=3, resetn low 2 cycles.
  - During reset: scan_select=4'b1111, seg7=8'h00, frame_done=0.
  - One cycle after release: scan_select=4'b1110, seg7=8'h7E.
- Scan rate: load digits_in=16'h4321.
  - Each select holds 3 cycles, in the order 1110, 1101, 1011, 0111.
  - seg7 shows 30, 6D, 79, 33.
  - frame_done pulses once per 12 cycles, coincident with the return to 1110.
- Leading-zero blanking: digits_in=16'h0070, lz_blank=1.
  - Digits 3 and 2 give seg7=00.
  - Digit 1 gives 70.
  - Digit 0 gives 7E.
  - With lz_blank=0, digits 3 and 2 give 7E.
- Decimal point: dp_in=4'b0100 with 16'h0000 → digit 2 gives seg7=FE; all others give 7E.
- Hex/invalid codes: digits_in=16'hFA00.
  - With SEG7_HEX_EN: digit 3 gives 47, digit 2 gives 77.
  - Without SEG7_HEX_EN: both give 00.
- Simultaneous events:
  - load asserted on the terminal-count edge → the next digit shows the new value.
  - load with resetn=0 → the shadow registers stay 0.
  - resetn pulsed mid-frame → the scan restarts at digit 0 with no frame_done pulse.
